// File: rtl/cgra_stream_pkg.sv
// Shared definitions for the CGRA word-stream blocks.
// Holds the default widths and the stream producer state encoding.
package cgra_stream_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/stream_source_if.sv
// Control, scratchpad read port and output stream of stream_source.
// The master modport is the producer's view; slave is the surrounding fabric.
interface stream_source_if #(
  parameter int DATA_W = cgra_stream_pkg::DATA_W_DEF,
  parameter int ADDR_W = cgra_stream_pkg::ADDR_W_DEF,
  parameter int CNT_W  = cgra_stream_pkg::CNT_W_DEF
) ();

  logic              io_start;
  logic [ADDR_W-1:0] io_base;
  logic [ADDR_W-1:0] io_stride;
  logic [CNT_W-1:0]  io_count;
  logic              io_busy;
  logic              io_done;
  logic              io_mem_en;
  logic [ADDR_W-1:0] io_mem_addr;
  logic [DATA_W-1:0] io_mem_rdata;
  logic [DATA_W-1:0] io_dout;
  logic              io_dout_v;
  logic              io_dout_r;

  modport master (
    input  io_start, io_base, io_stride, io_count, io_mem_rdata, io_dout_r,
    output io_busy, io_done, io_mem_en, io_mem_addr, io_dout, io_dout_v
  );

  modport slave (
    output io_start, io_base, io_stride, io_count, io_mem_rdata, io_dout_r,
    input  io_busy, io_done, io_mem_en, io_mem_addr, io_dout, io_dout_v
  );

endinterface

// File: rtl/stream_skid2.sv
// Two-entry FIFO with registered head word; valid is decoded from occupancy only,
// so it never depends on the downstream ready.
module stream_skid2 #(
  parameter int DATA_W = cgra_stream_pkg::DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_v,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_v,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_r,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] tail_r;
  logic [1:0]        occ_r;

  // Occupancy and entry update; the producer never pushes into a full buffer without a pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r <= '0;
      tail_r <= '0;
      occ_r  <= 2'd0;
    end else begin
      case (occ_r)
        2'd0: begin
          if (in_v) begin
            head_r <= in_data;
            occ_r  <= 2'd1;
          end
        end
        2'd1: begin
          if (in_v && out_r) begin
            head_r <= in_data;
          end else if (in_v) begin
            tail_r <= in_data;
            occ_r  <= 2'd2;
          end else if (out_r) begin
            occ_r  <= 2'd0;
          end
        end
        2'd2: begin
          if (out_r) begin
            head_r <= tail_r;
            if (in_v) begin
              tail_r <= in_data;
            end else begin
              occ_r  <= 2'd1;
            end
          end
        end
        default: begin
          occ_r <= 2'd0;
        end
      endcase
    end
  end

  assign out_v    = (occ_r != 2'd0);
  assign out_data = head_r;
  assign occ      = occ_r;

endmodule

// File: rtl/stream_source.sv
// Stream producer: walks a scratchpad (base, stride, count) with 1-cycle-latency reads
// and emits the words on a valid/ready stream through a 2-entry buffer.
module stream_source
  import cgra_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  stream_source_if.master  io
);

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] stride_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  issued_r;
  logic [CNT_W-1:0]  emitted_r;
  logic              in_flight_r;

  logic              dout_v_s;
  logic [DATA_W-1:0] dout_s;
  logic [1:0]        occ_s;
  logic              pop_s;
  logic [2:0]        pending_s;
  logic              mem_en_s;
  logic              last_issue_s;
  logic              last_emit_s;

  stream_skid2 #(.DATA_W(DATA_W)) u_buf (
    .clock    (clock),
    .reset    (reset),
    .in_v     (in_flight_r),
    .in_data  (io.io_mem_rdata),
    .out_v    (dout_v_s),
    .out_data (dout_s),
    .out_r    (io.io_dout_r),
    .occ      (occ_s)
  );

  assign pop_s        = dout_v_s & io.io_dout_r;
  assign last_issue_s = (issued_r == (count_r - CNT_W'(1)));
  assign last_emit_s  = (emitted_r == (count_r - CNT_W'(1)));

  // Issue a read only if the word still fits after this cycle's pop and the pending return.
  always_comb begin
    pending_s = {1'b0, occ_s} + {2'b00, in_flight_r} - {2'b00, pop_s};
    mem_en_s  = 1'b0;
    if ((state_r == S_RUN) && (pending_s < 3'd2)) begin
      mem_en_s = 1'b1;
    end else begin
      mem_en_s = 1'b0;
    end
  end

  // Transfer FSM with address generator, counters and the read-in-flight flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      addr_r      <= '0;
      stride_r    <= '0;
      count_r     <= '0;
      issued_r    <= '0;
      emitted_r   <= '0;
      in_flight_r <= 1'b0;
    end else begin
      in_flight_r <= mem_en_s;
      done_r      <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (io.io_start) begin
            addr_r    <= io.io_base;
            stride_r  <= io.io_stride;
            count_r   <= io.io_count;
            issued_r  <= '0;
            emitted_r <= '0;
            if (io.io_count == '0) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_RUN;
              busy_r  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (mem_en_s) begin
            addr_r   <= addr_r + stride_r;
            issued_r <= issued_r + CNT_W'(1);
            if (last_issue_s) begin
              state_r <= S_DRAIN;
            end
          end
          if (pop_s) begin
            emitted_r <= emitted_r + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (pop_s) begin
            emitted_r <= emitted_r + CNT_W'(1);
            if (last_emit_s) begin
              state_r <= S_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign io.io_busy     = busy_r;
  assign io.io_done     = done_r;
  assign io.io_mem_en   = mem_en_s;
  assign io.io_mem_addr = addr_r;
  assign io.io_dout     = dout_s;
  assign io.io_dout_v   = dout_v_s;

endmodule

// File: tb/tb_stream_source.sv
// Scoreboard bench for stream_source: a reference model queues expected addresses and
// words per transfer; a negedge monitor checks reads, stream words, holding and occupancy.
module tb_stream_source;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  stream_source_if #(.DATA_W(32), .ADDR_W(10), .CNT_W(16)) sif ();

  stream_source #(.DATA_W(32), .ADDR_W(10), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .io    (sif)
  );

  logic [31:0] mem [1024];
  int          checks = 0;
  int          errors = 0;
  int          mode   = 0;
  int          addr_q[$];
  logic [31:0] exp_q[$];

  // scratchpad model, one-cycle read latency
  always @(posedge clock) begin
    if (sif.io_mem_en) sif.io_mem_rdata <= mem[sif.io_mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // reference model: address k is base + k*stride (signed) modulo 1024
  task automatic model_xfer(input int base, input int stride, input int count);
    int s;
    int a;
    s = (stride >= 512) ? stride - 1024 : stride;
    for (int k = 0; k < count; k++) begin
      a = ((base + k * s) % 1024 + 1024) % 1024;
      addr_q.push_back(a);
      exp_q.push_back(mem[a]);
    end
  endtask

  task automatic start_xfer(input logic [9:0] b, input logic [9:0] s, input logic [15:0] c);
    @(posedge clock);
    #1;
    sif.io_start  = 1'b1;
    sif.io_base   = b;
    sif.io_stride = s;
    sif.io_count  = c;
    model_xfer(int'(b), int'(s), int'(c));
    @(posedge clock);
    #1;
    sif.io_start = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clock);
      if (sif.io_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("done_timeout");
  endtask

  task automatic check_drained();
    check("words_left", addr_q.size() + exp_q.size(), 32'd0);
  endtask

  // downstream ready pattern generator
  initial begin
    int phase;
    phase = 0;
    sif.io_dout_r = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (mode)
        0: sif.io_dout_r = 1'b1;
        1: begin
          sif.io_dout_r = ((phase % 4) == 0) || ((phase % 4) == 3);
          phase++;
        end
        2: sif.io_dout_r = 1'($urandom_range(0, 1));
        3: sif.io_dout_r = 1'b0;
        default: sif.io_dout_r = 1'b1;
      endcase
    end
  end

  // monitor: reads, stream words, holding under backpressure, occupancy bound
  initial begin
    int          iss;
    int          pops;
    bit          prev_hold;
    logic [31:0] prev_data;
    iss = 0; pops = 0; prev_hold = 1'b0; prev_data = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        iss = 0; pops = 0; prev_hold = 1'b0;
      end else begin
        if (sif.io_busy) check("outstanding_le_2", 32'(iss - pops <= 2), 32'd1);
        if (sif.io_mem_en) begin
          if (addr_q.size() == 0) fail_now("spurious_read");
          else check("mem_addr", 32'(sif.io_mem_addr), 32'(addr_q.pop_front()));
          iss++;
        end
        if (prev_hold) begin
          check("hold_valid", 32'(sif.io_dout_v), 32'd1);
          check("hold_data", sif.io_dout, prev_data);
        end
        if (sif.io_dout_v && sif.io_dout_r) begin
          if (exp_q.size() == 0) fail_now("spurious_word");
          else check("dout", sif.io_dout, exp_q.pop_front());
          pops++;
        end
        prev_hold = sif.io_dout_v && !sif.io_dout_r;
        prev_data = sif.io_dout;
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    reset         = 1'b1;
    sif.io_start  = 1'b0;
    sif.io_base   = '0;
    sif.io_stride = '0;
    sif.io_count  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(sif.io_busy), 32'd0);
    check("rst_done", 32'(sif.io_done), 32'd0);
    check("rst_mem_en", 32'(sif.io_mem_en), 32'd0);
    check("rst_dout_v", 32'(sif.io_dout_v), 32'd0);
    check("rst_dout", sif.io_dout, 32'd0);
    check("rst_mem_addr", 32'(sif.io_mem_addr), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // exact latency with ready held high
    mode = 0;
    start_xfer(10'd5, 10'd1, 16'd4);
    @(negedge clock);
    check("t1_en", 32'(sif.io_mem_en), 32'd1);
    check("t1_addr", 32'(sif.io_mem_addr), 32'd5);
    check("t1_busy", 32'(sif.io_busy), 32'd1);
    @(negedge clock);
    @(negedge clock);
    check("t3_v", 32'(sif.io_dout_v), 32'd1);
    check("t3_dout", sif.io_dout, mem[5]);
    repeat (3) @(negedge clock);
    check("t6_v", 32'(sif.io_dout_v), 32'd1);
    check("t6_dout", sif.io_dout, mem[8]);
    @(negedge clock);
    check("t7_done", 32'(sif.io_done), 32'd1);
    check("t7_v", 32'(sif.io_dout_v), 32'd0);
    check_drained();

    // address wrap, positive and negative stride
    start_xfer(10'd1020, 10'd3, 16'd3);
    wait_done();
    check_drained();
    start_xfer(10'd1, 10'h3FE, 16'd2);
    wait_done();
    check_drained();

    // ready toggling 1,0,0,1
    mode = 1;
    start_xfer(10'($urandom_range(0, 1023)), 10'd1, 16'd8);
    wait_done();
    check_drained();

    // zero count: immediate done, no reads
    mode = 0;
    start_xfer(10'd100, 10'd1, 16'd0);
    @(negedge clock);
    check("c0_done", 32'(sif.io_done), 32'd1);
    check("c0_busy", 32'(sif.io_busy), 32'd0);
    check("c0_en", 32'(sif.io_mem_en), 32'd0);
    check("c0_v", 32'(sif.io_dout_v), 32'd0);
    @(negedge clock);
    check("c0_done_pulse", 32'(sif.io_done), 32'd0);
    check_drained();

    // start pulses while running are ignored
    mode = 2;
    start_xfer(10'd200, 10'd5, 16'd10);
    repeat (3) begin
      @(posedge clock);
      #1;
      sif.io_start  = 1'b1;
      sif.io_base   = 10'd0;
      sif.io_stride = 10'd7;
      sif.io_count  = 16'd3;
    end
    @(posedge clock);
    #1;
    sif.io_start = 1'b0;
    wait_done();
    check_drained();

    // reset with one word buffered and one read in flight
    mode = 3;
    start_xfer(10'd300, 10'd1, 16'd8);
    repeat (3) @(negedge clock);
    check("pre_rst_v", 32'(sif.io_dout_v), 32'd1);
    check("pre_rst_en", 32'(sif.io_mem_en), 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(sif.io_busy), 32'd0);
    check("mid_rst_v", 32'(sif.io_dout_v), 32'd0);
    check("mid_rst_dout", sif.io_dout, 32'd0);
    check("mid_rst_en", 32'(sif.io_mem_en), 32'd0);
    check("mid_rst_addr", 32'(sif.io_mem_addr), 32'd0);
    addr_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    mode = 0;
    start_xfer(10'd400, 10'd2, 16'd5);
    wait_done();
    check_drained();

    // randomized transfers
    for (int t = 0; t < 12; t++) begin
      mode = $urandom_range(0, 2);
      start_xfer(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 16'($urandom_range(1, 24)));
      wait_done();
      check_drained();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
